// File: rtl/spi_pkg.sv
// Shared constants for the SPI pin conditioner: channel map, defaults, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_CH_SCLK = 0;
    localparam int SPI_CH_CS   = 1;
    localparam int SPI_CH_MOSI = 2;

    localparam int              SPI_CHANNELS_DEFAULT = 3;
    localparam int              SPI_WAITTIME_DEFAULT = 3;
    localparam logic [2:0]      SPI_INIT_DEFAULT     = 3'b010;

    // Debounce counter must be able to hold 0..WAITTIME.
    function automatic int spiCntWidth(input int waitTime);
        return $clog2(waitTime + 1);
    endfunction

endpackage

// File: rtl/spi_input_conditioner_if.sv
// Pin-side and conditioned-side bundle for spi_input_conditioner; glitchCount only with SPI_COND_GLITCH_CNT_EN.
// Latency: n/a (wires only).
// Backpressure: none.
interface spi_input_conditioner_if #(
    parameter int CHANNELS = spi_pkg::SPI_CHANNELS_DEFAULT
);
    logic [CHANNELS-1:0] noisySignal;
    logic [CHANNELS-1:0] conditioned;
    logic [CHANNELS-1:0] positiveEdge;
    logic [CHANNELS-1:0] negativeEdge;
`ifdef SPI_COND_GLITCH_CNT_EN
    logic [7:0]          glitchCount;
`endif

    modport master (
        output noisySignal,
        input  conditioned,
        input  positiveEdge,
        input  negativeEdge
`ifdef SPI_COND_GLITCH_CNT_EN
        , input glitchCount
`endif
    );

    modport slave (
        input  noisySignal,
        output conditioned,
        output positiveEdge,
        output negativeEdge
`ifdef SPI_COND_GLITCH_CNT_EN
        , output glitchCount
`endif
    );

endinterface

// File: rtl/spi_cond_channel.sv
// One pin: 2-flop sync, WAITTIME-cycle debounce, registered edge pulses; abort strobe with SPI_COND_GLITCH_CNT_EN.
// Latency: pin change sampled at edge k appears at edge k+1+WAITTIME.
// Backpressure: none; the pin is sampled every cycle.
module spi_cond_channel
    import spi_pkg::*;
#(
    parameter int   WAITTIME = SPI_WAITTIME_DEFAULT,
    parameter logic INIT     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisySignal,
    output logic conditioned,
    output logic positiveEdge,
    output logic negativeEdge
`ifdef SPI_COND_GLITCH_CNT_EN
    , output logic abort
`endif
);

    localparam int            CW   = spiCntWidth(WAITTIME);
    localparam logic [CW-1:0] LAST = CW'(WAITTIME - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] counter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0        <= INIT;
            sync1        <= INIT;
            conditioned  <= INIT;
            positiveEdge <= 1'b0;
            negativeEdge <= 1'b0;
            counter      <= '0;
        end else begin
            sync0        <= noisySignal;
            sync1        <= sync0;
            positiveEdge <= 1'b0;
            negativeEdge <= 1'b0;
            if (sync1 == conditioned) begin
                // Level fell back before WAITTIME elapsed: pending transition is dropped.
                counter <= '0;
            end else if (counter == LAST) begin
                conditioned  <= sync1;
                positiveEdge <= sync1;
                negativeEdge <= ~sync1;
                counter      <= '0;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

`ifdef SPI_COND_GLITCH_CNT_EN
    assign abort = (counter != '0) && (sync1 == conditioned);
`endif

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions raw SCLK/CS/MOSI into clk domain; optional saturating glitchCount under SPI_COND_GLITCH_CNT_EN.
// Latency: 1+WAITTIME cycles from pin sample to conditioned level and edge pulse.
// Backpressure: none; all channels sampled every cycle in parallel.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int                  CHANNELS = SPI_CHANNELS_DEFAULT,
    parameter int                  WAITTIME = SPI_WAITTIME_DEFAULT,
    parameter logic [CHANNELS-1:0] INIT     = SPI_INIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    spi_input_conditioner_if.slave bus
);

    logic [CHANNELS-1:0] condVec;
    logic [CHANNELS-1:0] posVec;
    logic [CHANNELS-1:0] negVec;
`ifdef SPI_COND_GLITCH_CNT_EN
    logic [CHANNELS-1:0] abortVec;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : gCh
        spi_cond_channel #(
            .WAITTIME (WAITTIME),
            .INIT     (INIT[i])
        ) uCh (
            .clk          (clk),
            .reset_n      (reset_n),
            .noisySignal  (bus.noisySignal[i]),
            .conditioned  (condVec[i]),
            .positiveEdge (posVec[i]),
            .negativeEdge (negVec[i])
`ifdef SPI_COND_GLITCH_CNT_EN
            , .abort      (abortVec[i])
`endif
        );
    end

    assign bus.conditioned  = condVec;
    assign bus.positiveEdge = posVec;
    assign bus.negativeEdge = negVec;

`ifdef SPI_COND_GLITCH_CNT_EN
    logic [7:0] glitchCount;
    logic [8:0] glitchSum;

    // One extra bit catches overflow so the count can clamp at 8'hFF.
    always_comb begin
        glitchSum = {1'b0, glitchCount};
        for (int i = 0; i < CHANNELS; i++) begin
            glitchSum = glitchSum + {8'd0, abortVec[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitchCount <= 8'd0;
        end else begin
            glitchCount <= (glitchSum > 9'd255) ? 8'hFF : glitchSum[7:0];
        end
    end

    assign bus.glitchCount = glitchCount;
`endif

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed bench for spi_input_conditioner (WAITTIME=3, INIT=3'b010); glitch counter checks with SPI_COND_GLITCH_CNT_EN.
module tb_spi_input_conditioner;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    spi_input_conditioner_if #(.CHANNELS(3)) bus();

    spi_input_conditioner #(
        .CHANNELS (3),
        .WAITTIME (3),
        .INIT     (3'b010)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic [2:0] cond, input logic [2:0] pos, input logic [2:0] neg);
        check({tag, ".cond"}, {5'd0, bus.conditioned}, {5'd0, cond});
        check({tag, ".pos"},  {5'd0, bus.positiveEdge}, {5'd0, pos});
        check({tag, ".neg"},  {5'd0, bus.negativeEdge}, {5'd0, neg});
    endtask

    initial begin
        bus.noisySignal = 3'b010;

        // Reset and idle.
        tick();
        tick();
        checkOut("in_reset", 3'b010, 3'b000, 3'b000);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOut("idle", 3'b010, 3'b000, 3'b000);
        end
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_idle", bus.glitchCount, 8'd0);
`endif

        // Clean SCLK rise: sampled at edge k, accepted at k+4 only.
        bus.noisySignal[SPI_CH_SCLK] = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOut("sclk_wait", 3'b010, 3'b000, 3'b000);
        end
        tick();
        checkOut("sclk_rise", 3'b011, 3'b001, 3'b000);
        tick();
        checkOut("sclk_after", 3'b011, 3'b000, 3'b000);

        // MOSI high for 2 samples is filtered.
        bus.noisySignal[SPI_CH_MOSI] = 1'b1;
        tick();
        tick();
        bus.noisySignal[SPI_CH_MOSI] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOut("mosi_glitch", 3'b011, 3'b000, 3'b000);
        end
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_one", bus.glitchCount, 8'd1);
`endif

        // MOSI high for exactly 3 samples is accepted, then falls 4 edges after the low sample.
        bus.noisySignal[SPI_CH_MOSI] = 1'b1;
        tick();
        tick();
        tick();
        bus.noisySignal[SPI_CH_MOSI] = 1'b0;
        tick();
        checkOut("mosi_min_wait", 3'b011, 3'b000, 3'b000);
        tick();
        checkOut("mosi_min_rise", 3'b111, 3'b100, 3'b000);
        tick();
        checkOut("mosi_hold1", 3'b111, 3'b000, 3'b000);
        tick();
        checkOut("mosi_hold2", 3'b111, 3'b000, 3'b000);
        tick();
        checkOut("mosi_fall", 3'b011, 3'b000, 3'b100);
        tick();
        checkOut("mosi_fall_after", 3'b011, 3'b000, 3'b000);
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_still_one", bus.glitchCount, 8'd1);
`endif

        // Return SCLK low.
        bus.noisySignal = 3'b010;
        for (int i = 0; i < 6; i++) tick();
        checkOut("sclk_low", 3'b010, 3'b000, 3'b000);

        // Simultaneous CS fall and SCLK rise.
        bus.noisySignal = 3'b001;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOut("simul_wait", 3'b010, 3'b000, 3'b000);
        end
        tick();
        checkOut("simul_edge", 3'b001, 3'b001, 3'b010);
        tick();
        checkOut("simul_after", 3'b001, 3'b000, 3'b000);

        // Reset mid-debounce of a CS rise: outputs snap to INIT without a clock edge.
        bus.noisySignal = 3'b011;
        for (int i = 0; i < 4; i++) tick();
        checkOut("pre_reset", 3'b001, 3'b000, 3'b000);
        #2;
        reset_n = 1'b0;
        #1;
        checkOut("async_reset", 3'b010, 3'b000, 3'b000);
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_reset", bus.glitchCount, 8'd0);
`endif
        tick();
        tick();
        checkOut("held_reset", 3'b010, 3'b000, 3'b000);
        reset_n = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOut("post_reset_wait", 3'b010, 3'b000, 3'b000);
        end
        tick();
        checkOut("post_reset_rise", 3'b011, 3'b001, 3'b000);
        tick();
        checkOut("post_reset_after", 3'b011, 3'b000, 3'b000);

        // 300 one-sample MOSI glitches: always filtered, counter clamps.
        for (int g = 0; g < 300; g++) begin
            bus.noisySignal[SPI_CH_MOSI] = 1'b1;
            tick();
            bus.noisySignal[SPI_CH_MOSI] = 1'b0;
            tick();
            tick();
            tick();
            check("burst_cond", {5'd0, bus.conditioned}, 8'h03);
        end
        checkOut("burst_end", 3'b011, 3'b000, 3'b000);
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_saturate", bus.glitchCount, 8'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
